// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with shadowed digit data.
// Define SEG7_LZ_BLANK_EN to blank leading-zero digits.
module seg7_scan_ctrl #(
    parameter int unsigned NDIGIT   = 8,
    parameter int unsigned SCAN_DIV = 16'd50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*NDIGIT-1:0]   data_in,
    input  logic [NDIGIT-1:0]     dp_in,
    input  logic [NDIGIT-1:0]     en_in,
    input  logic                  freeze,
    output logic [NDIGIT-1:0]     an_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic                  slot_tick
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIGIT - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*NDIGIT-1:0]   data_sh;
    logic [NDIGIT-1:0]     dp_sh;
    logic [NDIGIT-1:0]     en_sh;
    logic [NDIGIT-1:0]     lz;
    logic [NDIGIT-1:0]     sel;
    logic                  advance;
    logic                  vis;
    logic [3:0]            nib;
    logic [NDIGIT-1:0]     an_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        unique case (v)
            4'h0: hex_glyph = 7'h40;
            4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;
            4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;
            4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;
            4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;
            4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;
            4'hF: hex_glyph = 7'h0E;
        endcase
    endfunction

    // A held terminal count stays terminal, so the advance fires on release.
    assign advance = !freeze && (cnt == CNT_LAST);

`ifdef SEG7_LZ_BLANK_EN
    always_comb begin
        logic zacc;
        lz   = '0;
        zacc = 1'b1;
        for (int i = int'(NDIGIT) - 1; i > 0; i--) begin
            zacc  = zacc & (data_sh[4*i +: 4] == 4'h0);
            lz[i] = zacc;
        end
    end
`else
    assign lz = '0;
`endif

    always_comb begin
        sel     = NDIGIT'(1) << idx;
        nib     = 4'(data_sh >> {idx, 2'b00});
        vis     = |(en_sh & ~lz & sel);
        an_nxt  = vis ? ~sel : '1;
        seg_nxt = vis ? hex_glyph(nib) : 7'h7F;
        dp_nxt  = vis ? ~|(dp_sh & sel) : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= '0;
            data_sh   <= '0;
            dp_sh     <= '0;
            en_sh     <= '0;
            an_n      <= '1;
            seg_n     <= 7'h7F;
            dp_n      <= 1'b1;
            slot_tick <= 1'b0;
        end else begin
            if (!freeze) begin
                cnt <= advance ? '0 : cnt + 1'b1;
            end
            if (advance) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            slot_tick <= advance;
            if (load) begin
                data_sh <= data_in;
                dp_sh   <= dp_in;
                en_sh   <= en_in;
            end
            an_n  <= an_nxt;
            seg_n <= seg_nxt;
            dp_n  <= dp_nxt;
        end
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter NDIGIT, default 8, meaning the number of multiplexed digits; legal range is 1..16.
REQ-002 SHALL have parameter SCAN_DIV, default 16'd50000, meaning the clocks per digit slot; legal range is >=1, and 1 means advance every clock.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port load, input, 1 bit: one-cycle strobe that captures data_in, dp_in and en_in into the shadow registers.
REQ-006 SHALL have port data_in, input, 4*NDIGIT bits: nibble i, bits [4i+3:4i], is the hex value for digit i.
REQ-007 SHALL have port dp_in, input, NDIGIT bits: bit i=1 lights the decimal point of digit i.
REQ-008 SHALL have port en_in, input, NDIGIT bits: bit i=0 blanks digit i.
REQ-009 SHALL have port freeze, input, 1 bit: 1 holds the scan position and divider.
REQ-010 SHALL have port an_n, output, NDIGIT bits: active-low digit selects, registered.
REQ-011 SHALL have port seg_n, output, 7 bits: active-low segments, bit0=a .. bit6=g, registered.
REQ-012 SHALL have port dp_n, output, 1 bit: active-low decimal point, registered.
REQ-013 SHALL have port slot_tick, output, 1 bit: one-cycle pulse, registered, asserted on the cycle idx advances.

Function
REQ-014 SHALL keep divider cnt counting 0..SCAN_DIV-1; at cnt==SCAN_DIV-1 it SHALL reset cnt to 0 and advance idx, wrapping NDIGIT-1 -> 0.
REQ-015 SHALL hold cnt and idx while freeze=1; a terminal count SHALL NOT be lost, and the advance SHALL occur on the first unfrozen terminal cycle.
REQ-016 SHALL register outputs from the current idx and shadow registers, giving a latency of exactly 1 clock from an idx change to an_n/seg_n/dp_n.
REQ-017 SHALL drive an_n with only bit idx low when digit idx is visible; otherwise all ones. There SHALL never be more than one bit low.
REQ-018 SHALL decode seg_n with standard hex 0-F glyphs: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-019 SHALL drive a blanked digit as an_n all ones, seg_n=7'h7F, dp_n=1; the blanked digit still consumes its time slot.
REQ-020 SHALL drive dp_n = ~dp_shadow[idx] when visible.
REQ-021 SHALL make shadow registers update on load at the clock edge; the value is used by the output register from the next edge.
REQ-022 SHALL, when load coincides with an idx advance, present the new digit with the new data one clock later and never with the old data.
REQ-023 SHALL ignore load while rst=1.
REQ-024 SHALL make freeze and load independent; load during freeze SHALL update the displayed glyph of the held digit with 1-clock latency.

Reset
REQ-025 SHALL, on rst=1, immediately set cnt=0, idx=0, all shadows=0, an_n=all ones, seg_n=7'h7F, dp_n=1, slot_tick=0.
REQ-026 SHALL restart scanning at digit 0 with cnt=0 after rst deasserts; because en is reset to 0, nothing is lit until the first load.
REQ-027 SHALL, on reset mid-slot or mid-freeze, discard all state and require no recovery cycles.

Configuration
REQ-028 SHALL support macro SEG7_LZ_BLANK_EN. Defined: digit i (i>0) is blanked when nibbles i..NDIGIT-1 are all zero, in addition to en_in; digit 0 is never blanked by this rule. Undefined: zeros display as "0" and blanking comes only from en_in.

Verification
REQ-029 NDIGIT=8, SCAN_DIV=4, load data=32'h1234ABCD, en=8'hFF -> an_n steps FE,FD,..,7F, 4 clocks each; seg_n on digit0=7'h21 (d) and on digit7=7'h79 (1); slot_tick every 4th clock.
REQ-030 SCAN_DIV=1 -> idx advances every clock; wrap 7 -> 0 has no gap; output lags idx by 1 clock.
REQ-031 freeze high for 10 clocks on digit 3 -> an_n=F7 held; release -> advance at the next terminal count; load during freeze changes seg_n after 1 clock.
REQ-032 en=8'h0F, dp=8'h01 -> digits 4-7 are dark (an_n all ones, seg_n=7'h7F) for their slots; dp_n=0 only on digit 0.
REQ-033 With SEG7_LZ_BLANK_EN, data=32'h00000050 -> digits 2-7 are blank, digit1=5, digit0=0. Without the macro, all 8 digits are lit.
REQ-034 rst pulse mid-slot of digit 5 -> outputs are at reset values in the same cycle; after release the scan starts at digit 0, dark until load.
